// File: rtl/blit_pkg.sv
// blit_pkg: shared types for the blitter pixel writer.
//   wr_entry_t     - one queued memory write {word address, 32-bit data, byte mask}
//   BLIT_PIX_BYTES - bytes per pixel (8bpp)
//   pix_entry()    - places one pixel byte into its lane of a word write
package blit_pkg;

    localparam int BLIT_ADDR_W    = 26;
    localparam int BLIT_WORD_W    = BLIT_ADDR_W - 2;
    localparam int BLIT_PIX_BYTES = 1;

    typedef struct packed {
        logic [BLIT_WORD_W-1:0] addr;
        logic [31:0]            data;
        logic [3:0]             mask;
    } wr_entry_t;

    // Single-pixel write: byte in its lane, all other bytes zero, one mask bit.
    function automatic wr_entry_t pix_entry(
        input logic [BLIT_WORD_W-1:0]      word,
        input logic [1:0]                  lane,
        input logic [8*BLIT_PIX_BYTES-1:0] pix
    );
        wr_entry_t e;
        e.addr = word;
        e.data = 32'(pix) << {lane, 3'b000};
        e.mask = 4'b0001 << lane;
        return e;
    endfunction

endpackage

// File: rtl/blit_pixel_writer_if.sv
// blit_pixel_writer_if: pixel stream in, memory write requests out.
//   master modport - the pixel writer (consumes pixels, issues mem_req)
//   slave modport  - pipeline + arbiter side (drives pixels and mem_ack)
// Signals: in_write/in_addr/in_data/flush -> writer; stall/idle -> pipeline;
//          mem_req/mem_addr/mem_wdata/mem_wmask -> arbiter; mem_ack -> writer.
interface blit_pixel_writer_if
    import blit_pkg::*;
#(
    parameter int ADDR_W = BLIT_ADDR_W
);
    logic              in_write;
    logic [ADDR_W-1:0] in_addr;
    logic [15:0]       in_data;
    logic              flush;
    logic              stall;
    logic              idle;
    logic              mem_req;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ack;

    modport master (
        input  in_write, in_addr, in_data, flush, mem_ack,
        output stall, idle, mem_req, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output in_write, in_addr, in_data, flush, mem_ack,
        input  stall, idle, mem_req, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/blit_wr_fifo.sv
// blit_wr_fifo: synchronous FIFO of wr_entry_t with a registered head.
// Ports: clock, reset (async, active-low), push/push_data, pop,
//        full, empty, count (one bit wider than the pointers), head.
// Caller never pushes when full nor pops when empty.
module blit_wr_fifo
    import blit_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  wr_entry_t   push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [PTR_W:0] count,
    output wr_entry_t   head
);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [PTR_W:0]   count_q, count_d;
    wr_entry_t        mem_q [DEPTH];
    wr_entry_t        head_q, head_d;

    assign rd_nxt = rd_ptr_q + PTR_W'(1);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Head holds the oldest entry; it only moves on pop or on a push into an
    // empty queue, so it is stable while a request waits for its ack.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count_q == (PTR_W+1)'(1)) begin
                if (push) head_d = push_data;
            end else begin
                head_d = mem_q[rd_nxt];
            end
        end else if (push && count_q == '0) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_nxt;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/blit_pixel_writer.sv
// blit_pixel_writer: packs 8bpp pixel writes into 32-bit word writes,
// queues them and issues them to the memory arbiter over req/ack.
// Ports: clock, reset (async, active-low), bus (blit_pixel_writer_if.master).
// Build option BLIT_WRITE_COMBINE_EN: when defined, a combine register merges
// consecutive pixels of one word (drained by flush); when undefined every
// pixel is queued as its own single-byte write and flush is ignored.
module blit_pixel_writer
    import blit_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = BLIT_ADDR_W
) (
    input logic                 clock,
    input logic                 reset,
    blit_pixel_writer_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             push, pop, fifo_full, fifo_empty, accept;
    logic [CNT_W-1:0] fifo_count;
    wr_entry_t        push_data, head, pix;

    // Conservative: a pop in the same cycle does not release the stall.
    assign bus.stall = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign accept    = bus.in_write & ~bus.stall;
    assign pix       = pix_entry(bus.in_addr[ADDR_W-1:2], bus.in_addr[1:0], bus.in_data[7:0]);

    logic unused_hi;
    assign unused_hi = ^bus.in_data[15:8];

`ifdef BLIT_WRITE_COMBINE_EN
    wr_entry_t   cur_q, cur_d;
    logic        cur_valid_q, cur_valid_d;
    logic [31:0] pix_bytes;

    always_comb begin
        pix_bytes = '0;
        for (int i = 0; i < 4; i++) pix_bytes[8*i +: 8] = {8{pix.mask[i]}};
    end

    always_comb begin
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        push        = 1'b0;
        push_data   = cur_q;
        if (accept) begin
            if (cur_valid_q && cur_q.addr == pix.addr) begin
                cur_d.data = (cur_q.data & ~pix_bytes) | pix.data;
                cur_d.mask = cur_q.mask | pix.mask;
            end else begin
                // New word: retire the old one first; stall=0 guarantees room.
                push        = cur_valid_q;
                cur_d       = pix;
                cur_valid_d = 1'b1;
            end
        end else if (bus.flush && cur_valid_q && !fifo_full) begin
            push        = 1'b1;
            cur_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
        end
    end

    assign bus.idle = ~cur_valid_q & fifo_empty;
`else
    assign push      = accept;
    assign push_data = pix;
    assign bus.idle  = fifo_empty;

    logic unused_flush;
    assign unused_flush = bus.flush ^ fifo_full;
`endif

    assign pop = ~fifo_empty & bus.mem_ack;

    blit_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    assign bus.mem_req   = ~fifo_empty;
    assign bus.mem_addr  = head.addr;
    assign bus.mem_wdata = head.data;
    assign bus.mem_wmask = head.mask;

endmodule
